// File: rtl/word_rx_pkg.sv
// Shared types and constants for the serial word receiver.
//   state_e        : receiver states (IDLE, DATA, STOP)
//   WIDTH_DEF      : default number of data bits per frame
//   ERR_CNT_W_DEF  : default width of the saturating error counter
package word_rx_pkg;

    localparam int unsigned WIDTH_DEF     = 10;
    localparam int unsigned ERR_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_e;

endpackage

// File: rtl/seq_checker.sv
// Tracks the word expected next and flags words that break the sequence.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_check        : a correctly framed word is being accepted this cycle
//   i_word         : the word being accepted
//   o_mismatch_c   : combinational, i_word differs from the expected value
module seq_checker
    import word_rx_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_check,
    input  logic [WIDTH-1:0] i_word,
    output logic             o_mismatch_c
);

    logic [WIDTH-1:0] expected_q;
    logic [WIDTH-1:0] expected_d;

    assign o_mismatch_c = (i_word != expected_q);

    // Every accepted word resyncs the expectation; the add wraps modulo 2^WIDTH.
    always_comb begin
        expected_d = expected_q;
        if (i_check) begin
            expected_d = i_word + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            expected_q <= '0;
        end else begin
            expected_q <= expected_d;
        end
    end

endmodule

// File: rtl/word_receiver.sv
// Strobed serial word receiver: start 0, WIDTH data bits LSB first, stop 1.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_bit_en       : bit strobe; i_rx sampled only when high
//   i_rx           : serial line (idle high)
//   o_word         : last correctly framed word
//   o_word_valid   : one-cycle pulse, o_word updated
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_seq_err      : one-cycle pulse with o_word_valid, word out of sequence
//   o_busy         : frame in progress (DATA or STOP)
//   o_err_cnt      : saturating count of frame and sequence errors
module word_receiver
    import word_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_bit_en,
    input  logic                 i_rx,
    output logic [WIDTH-1:0]     o_word,
    output logic                 o_word_valid,
    output logic                 o_frame_err,
    output logic                 o_seq_err,
    output logic                 o_busy,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic [WIDTH-1:0]     word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 seq_q, seq_d;
    logic                 busy_q, busy_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 check_c;
    logic                 mismatch_c;

    seq_checker #(
        .WIDTH (WIDTH)
    ) u_seq_checker (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_check      (check_c),
        .i_word       (shift_q),
        .o_mismatch_c (mismatch_c)
    );

    // Next-state and output decode; pulses default low so they last one cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        check_c = 1'b0;

        if (i_bit_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!i_rx) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    shift_d[idx_q] = i_rx;
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        state_d = STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                STOP: begin
                    // Returning to IDLE means a start bit needs a later strobe.
                    state_d = IDLE;
                    if (i_rx) begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                        check_c = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Sequence errors only exist on accepted words, so they never share a frame with a frame error.
        seq_d  = check_c & mismatch_c;
        busy_d = (state_d != IDLE);

        cnt_d = cnt_q;
        if ((ferr_d || seq_d) && (cnt_q != '1)) begin
            cnt_d = cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            seq_q   <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            seq_q   <= seq_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_word       = word_q;
    assign o_word_valid = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_seq_err    = seq_q;
    assign o_busy       = busy_q;
    assign o_err_cnt    = cnt_q;

endmodule

// File: tb/tb_word_receiver.sv
// Directed plus randomized bench for word_receiver with a frame-level reference model.
module tb_word_receiver;

    localparam int unsigned W      = 10;
    localparam int unsigned CW     = 8;
    localparam int unsigned MOD    = 1 << W;
    localparam int unsigned CNTMAX = (1 << CW) - 1;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_bit_en;
    logic          i_rx;
    logic [W-1:0]  o_word;
    logic          o_word_valid;
    logic          o_frame_err;
    logic          o_seq_err;
    logic          o_busy;
    logic [CW-1:0] o_err_cnt;

    int unsigned n_checks;
    int unsigned n_err;

    // Reference model state, kept per frame rather than per bit.
    int unsigned m_expected;
    int unsigned m_word;
    int unsigned m_cnt;

    word_receiver #(
        .WIDTH     (W),
        .ERR_CNT_W (CW)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_bit_en     (i_bit_en),
        .i_rx         (i_rx),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .o_frame_err  (o_frame_err),
        .o_seq_err    (o_seq_err),
        .o_busy       (o_busy),
        .o_err_cnt    (o_err_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, leave the caller just after the rising edge.
    task automatic tick(input logic en, input logic rx);
        @(negedge i_clk);
        i_bit_en = en;
        i_rx     = rx;
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycles(input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            tick(1'b0, 1'($urandom));
        end
    endtask

    task automatic model_reset();
        m_expected = 0;
        m_word     = 0;
        m_cnt      = 0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 32'(o_word_valid), 32'd0);
        chk({tag, "_ferr"},  32'(o_frame_err),  32'd0);
        chk({tag, "_seq"},   32'(o_seq_err),    32'd0);
    endtask

    // Send one frame with gap non-strobe cycles after each strobe, then check against the model.
    task automatic send_frame(input int unsigned word, input logic stop_bit, input int unsigned gap);
        logic exp_seq;
        tick(1'b1, 1'b0);
        chk("busy_after_start", 32'(o_busy), 32'd1);
        idle_cycles(gap);
        for (int i = 0; i < int'(W); i++) begin
            tick(1'b1, 1'((word >> i) & 1));
            idle_cycles(gap);
        end
        chk("busy_before_stop", 32'(o_busy), 32'd1);
        chk_quiet("mid_frame");
        tick(1'b1, stop_bit);

        exp_seq = 1'b0;
        if (stop_bit) begin
            exp_seq    = (word != m_expected);
            m_expected = (word + 1) % MOD;
            m_word     = word;
        end
        if ((!stop_bit || exp_seq) && m_cnt < CNTMAX) m_cnt++;

        chk("word_valid", 32'(o_word_valid), 32'(stop_bit));
        chk("frame_err",  32'(o_frame_err),  32'(!stop_bit));
        chk("seq_err",    32'(o_seq_err),    32'(exp_seq));
        chk("word",       32'(o_word),       32'(m_word));
        chk("err_cnt",    32'(o_err_cnt),    32'(m_cnt));
        chk("busy_after_stop", 32'(o_busy),  32'd0);

        // Pulses last exactly one cycle.
        tick(1'b0, 1'b1);
        chk_quiet("after_pulse");
    endtask

    initial begin
        int unsigned w;
        logic        stop_bit;
        n_checks = 0;
        n_err    = 0;
        model_reset();
        i_bit_en = 1'b0;
        i_rx     = 1'b1;
        i_rst_n  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_word",  32'(o_word),    32'd0);
        chk("rst_busy",  32'(o_busy),    32'd0);
        chk("rst_cnt",   32'(o_err_cnt), 32'd0);
        chk_quiet("rst");
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Frame 0 with a strobe every cycle.
        send_frame(0, 1'b1, 0);
        // Frames 1..3 with two non-strobe cycles between strobes.
        for (int f = 1; f <= 3; f++) send_frame(f, 1'b1, 2);
        // Out-of-sequence word, then resync.
        send_frame(7, 1'b1, 0);
        send_frame(8, 1'b1, 1);
        // Wrap-around 1022, 1023, 0 (the jump to 1022 itself is a sequence error).
        send_frame(1022, 1'b1, 0);
        send_frame(1023, 1'b1, 0);
        send_frame(0, 1'b1, 0);
        // Bad stop bit: word discarded.
        send_frame(5, 1'b0, 1);
        // An idle strobe right after a frame must not start a frame.
        tick(1'b1, 1'b1);
        chk("idle_strobe_busy", 32'(o_busy), 32'd0);

        // Reset after data bit 4 of a frame.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'(i & 1));
        chk("busy_pre_reset", 32'(o_busy), 32'd1);
        @(negedge i_clk);
        i_bit_en = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_busy", 32'(o_busy),    32'd0);
        chk("mrst_word", 32'(o_word),    32'd0);
        chk("mrst_cnt",  32'(o_err_cnt), 32'd0);
        chk_quiet("mrst");
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick(1'b1, 1'b1);
        chk("post_rst_idle", 32'(o_busy), 32'd0);
        send_frame(0, 1'b1, 0);

        // Randomized frames: mostly in sequence, some jumps and bad stop bits.
        for (int f = 0; f < 40; f++) begin
            w        = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MOD - 1) : m_expected;
            stop_bit = ($urandom_range(0, 5) != 0);
            idle_cycles($urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) tick(1'b1, 1'b1);
            send_frame(w, stop_bit, $urandom_range(0, 2));
        end

        // Drive the error counter into saturation.
        for (int f = 0; f < int'(CNTMAX) + 4; f++) begin
            send_frame($urandom_range(0, MOD - 1), 1'b0, 0);
        end
        chk("cnt_saturated", 32'(o_err_cnt), 32'(CNTMAX));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/word_receiver.md
WORD_RECEIVER -- requirements
Module: word_receiver

Interface
REQ-001 Parameter: WIDTH, default 10, data bits per frame.
REQ-002 Parameter: ERR_CNT_W, default 8, width of the saturating error counter.
REQ-003 Port: i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: i_bit_en  input  1  bit strobe; i_rx is sampled only in cycles where this is high.
REQ-006 Port: i_rx  input  1  serial line; idle high, start 0, WIDTH data bits LSB first, stop 1.
REQ-007 Port: o_word  output  WIDTH  last correctly framed word.
REQ-008 Port: o_word_valid  output  1  one-cycle pulse, o_word updated.
REQ-009 Port: o_frame_err  output  1  one-cycle pulse, stop bit sampled as 0.
REQ-010 Port: o_seq_err  output  1  one-cycle pulse coincident with o_word_valid, word not equal to expected.
REQ-011 Port: o_busy  output  1  high while a frame is in progress (DATA or STOP).
REQ-012 Port: o_err_cnt  output  ERR_CNT_W  count of frame plus sequence errors, saturating.

Function
REQ-013 States SHALL be IDLE, DATA and STOP; cycles with i_bit_en low SHALL change nothing except clearing the pulse outputs.
REQ-014 In IDLE, a strobe with i_rx=0 SHALL go to DATA with bit index 0; a strobe with i_rx=1 SHALL stay in IDLE.
REQ-015 In DATA, each strobe SHALL write i_rx into shift bit [index], LSB first, and increment the index; the strobe for bit WIDTH-1 SHALL go to STOP.
REQ-016 In STOP, a strobe with i_rx=1 SHALL update o_word from the shift register, pulse o_word_valid, and go to IDLE.
REQ-017 In STOP, a strobe with i_rx=0 SHALL discard the word, pulse o_frame_err, leave o_word unchanged, and go to IDLE.
REQ-018 All outputs SHALL be registered; pulses SHALL be high for exactly the one cycle following the stop-bit sampling edge.
REQ-019 An expected-value register SHALL exist, initialised to 0.
REQ-020 On each valid word: o_seq_err = (word != expected); expected SHALL then become word+1 mod 2^WIDTH, which resyncs after a gap.
REQ-021 Wrap-around: expected 2^WIDTH-1 followed by word 0 SHALL NOT raise o_seq_err.
REQ-022 o_err_cnt SHALL increment by 1 on each o_frame_err or o_seq_err pulse and hold at 2^ERR_CNT_W-1.
REQ-023 A frame error and a sequence error SHALL never occur in the same frame.
REQ-024 A start bit SHALL NOT be accepted in the same strobe as a stop bit; a new frame begins on a later strobe.
REQ-025 o_busy SHALL be high exactly while the state is DATA or STOP.

Reset
REQ-026 i_rst_n low SHALL immediately force: state IDLE, index 0, shift register 0, o_word 0, all pulses 0, o_busy 0, o_err_cnt 0, expected 0.
REQ-027 Reset mid-frame SHALL abort the frame with no pulse; after release, reception restarts at the next start bit.

Structure
REQ-028 Package word_rx_pkg SHALL hold the state enum (IDLE, DATA, STOP) and the default WIDTH constant of 10.
REQ-029 Sub-module seq_checker SHALL hold the expected register, the comparison and the wrap increment; the FSM and shifter stay in word_receiver.

Verification
REQ-030 Reset, then frame 0 with a strobe every cycle -> o_word=0, o_word_valid for 1 cycle, o_seq_err=0, o_err_cnt=0.
REQ-031 Frames 1, 2, 3 with 2 idle cycles between strobes -> three valid pulses, o_word 1/2/3, no errors; non-strobe cycles ignored.
REQ-032 Frames 1022, 1023, 0 -> no o_seq_err, including on the 1023->0 wrap.
REQ-033 After word 3, frame 7 -> o_word=7 with o_seq_err=1 and o_err_cnt=1; then frame 8 -> no error.
REQ-034 Frame 5 with stop bit 0 -> o_frame_err pulse, no o_word_valid, o_word unchanged, o_err_cnt increments.
REQ-035 i_rst_n low after data bit 4 -> o_busy=0 and all outputs 0; a clean frame 0 afterwards is accepted with no error.
